// File: rtl/led_flash_if.sv
// Bundle between timebase/control source and the LED flash controller.
// Master drives count, enable and mode; slave returns LED, tick and run status.
interface led_flash_if #(
  parameter int LED_W = 8
);
  logic [31:0]      i_counter;
  logic             i_enable;
  logic [1:0]       i_mode;
  logic [LED_W-1:0] o_led;
  logic             o_tick;
  logic             o_running;

  modport master (
    output i_counter,
    output i_enable,
    output i_mode,
    input  o_led,
    input  o_tick,
    input  o_running
  );

  modport slave (
    input  i_counter,
    input  i_enable,
    input  i_mode,
    output o_led,
    output o_tick,
    output o_running
  );
endinterface

// File: rtl/led_flash_ctrl.sv
// LED pattern generator stepped by rising edges of one timebase count bit.
// Modes: blink, chase, ping-pong, binary count.
module led_flash_ctrl #(
  parameter int LED_W    = 8,
  parameter int TICK_BIT = 24
) (
  input  logic        i_clk,
  input  logic        i_reset,
  led_flash_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_BLINK = 2'd0;
  localparam logic [1:0] M_CHASE = 2'd1;
  localparam logic [1:0] M_PING  = 2'd2;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;

  logic             rise;
  logic             same_mode;
  logic [LED_W-1:0] step_led;
  logic             step_dir;
  logic             unused_cnt;

  assign unused_cnt = ^bus.i_counter;

  function automatic logic [LED_W-1:0] init_led(
    input logic [1:0] m
  );
    logic [LED_W-1:0] v;
    case (m)
      M_BLINK: v = '1;
      M_CHASE: v = LED_W'(1);
      M_PING:  v = LED_W'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

  assign rise      = bus.i_counter[TICK_BIT] & ~prev_q;
  assign same_mode = (bus.i_mode == mode_q);

  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    case (mode_q)
      M_BLINK: step_led = ~led_q;
      M_CHASE: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      M_PING: begin
        // Bounce at either end so exactly one LED stays lit.
        if (dir_q == DIR_L) begin
          if (led_q[LED_W-1]) begin
            step_led = led_q >> 1;
            step_dir = DIR_R;
          end else begin
            step_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_led = led_q << 1;
            step_dir = DIR_L;
          end else begin
            step_led = led_q >> 1;
          end
        end
      end
      default: step_led = led_q + LED_W'(1);
    endcase
  end

  always_comb begin
    prev_d  = bus.i_counter[TICK_BIT];
    tick_d  = rise;
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        led_d = '0;
        if (bus.i_enable) begin
          state_d = S_RUN;
          mode_d  = bus.i_mode;
          led_d   = init_led(bus.i_mode);
          dir_d   = DIR_L;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          !bus.i_enable: begin
            state_d = S_IDLE;
            led_d   = '0;
          end
          bus.i_enable && rise && same_mode: begin
            led_d = step_led;
            dir_d = step_dir;
          end
          bus.i_enable && rise && !same_mode: begin
            mode_d = bus.i_mode;
            led_d  = init_led(bus.i_mode);
            dir_d  = DIR_L;
          end
          default: ;
        endcase
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase
  end

  // prev resets high so a bit already set at release does not tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b1;
      tick_q  <= 1'b0;
      mode_q  <= M_BLINK;
      dir_q   <= DIR_L;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
    end
  end

  assign bus.o_led     = led_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_running = (state_q == S_RUN);

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Scoreboard bench for led_flash_ctrl: LED_W=8 and LED_W=4 instances
// share stimulus; a behavioural model predicts every cycle.
module tb_led_flash_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] cnt;
  logic        en;
  logic [1:0]  mode;

  int n_cmp;
  int n_err;

  led_flash_if #(.LED_W(8)) bus8 ();
  led_flash_if #(.LED_W(4)) bus4 ();

  assign bus8.i_counter = cnt;
  assign bus8.i_enable  = en;
  assign bus8.i_mode    = mode;
  assign bus4.i_counter = cnt;
  assign bus4.i_enable  = en;
  assign bus4.i_mode    = mode;

  led_flash_ctrl #(.LED_W(8), .TICK_BIT(2)) dut8 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus8.slave)
  );

  led_flash_ctrl #(.LED_W(4), .TICK_BIT(2)) dut4 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led8;
    logic [3:0] led4;
    logic       tick;
    logic       run;
  } exp_t;

  exp_t sb[$];

  logic       m_prev;
  logic       m_run;
  logic [1:0] m_mode;
  logic       m_dir8;
  logic       m_dir4;
  logic [7:0] m_led8;
  logic [3:0] m_led4;
  logic       m_tick;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_w(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  function automatic logic [31:0] init_fn(input logic [1:0] m,
                                          input int w);
    case (m)
      2'd0:    return mask_w(w);
      2'd1:    return 32'd1;
      2'd2:    return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [32:0] step_fn(input logic [1:0] m,
                                          input logic [31:0] v,
                                          input int w,
                                          input logic dir);
    logic [31:0] msk;
    logic [31:0] r;
    logic        d;
    msk = mask_w(w);
    d   = dir;
    case (m)
      2'd0: r = ~v & msk;
      2'd1: r = ((v << 1) | (v >> (w - 1))) & msk;
      2'd2: begin
        if (!dir) begin
          if (v[w-1]) begin r = v >> 1; d = 1'b1; end
          else r = (v << 1) & msk;
        end else begin
          if (v[0]) begin r = (v << 1) & msk; d = 1'b0; end
          else r = v >> 1;
        end
      end
      default: r = (v + 32'd1) & msk;
    endcase
    return {d, r};
  endfunction

  task automatic model_reset();
    m_prev = 1'b1;
    m_run  = 1'b0;
    m_mode = 2'd0;
    m_dir8 = 1'b0;
    m_dir4 = 1'b0;
    m_led8 = '0;
    m_led4 = '0;
    m_tick = 1'b0;
  endtask

  task automatic model_step();
    logic        rise;
    logic [32:0] r;
    if (rst) begin
      model_reset();
      return;
    end
    rise   = cnt[2] & ~m_prev;
    m_prev = cnt[2];
    m_tick = rise;
    if (!m_run) begin
      if (en) begin
        m_run  = 1'b1;
        m_mode = mode;
        m_led8 = init_fn(mode, 8)[7:0];
        m_led4 = init_fn(mode, 4)[3:0];
        m_dir8 = 1'b0;
        m_dir4 = 1'b0;
      end
    end else if (!en) begin
      m_run  = 1'b0;
      m_led8 = '0;
      m_led4 = '0;
    end else if (rise) begin
      if (mode == m_mode) begin
        r      = step_fn(m_mode, {24'd0, m_led8}, 8, m_dir8);
        m_led8 = r[7:0];
        m_dir8 = r[32];
        r      = step_fn(m_mode, {28'd0, m_led4}, 4, m_dir4);
        m_led4 = r[3:0];
        m_dir4 = r[32];
      end else begin
        m_mode = mode;
        m_led8 = init_fn(mode, 8)[7:0];
        m_led4 = init_fn(mode, 4)[3:0];
        m_dir8 = 1'b0;
        m_dir4 = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    e.led8 = m_led8;
    e.led4 = m_led4;
    e.tick = m_tick;
    e.run  = m_run;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("led8", {24'd0, bus8.o_led}, {24'd0, e.led8});
    chk("led4", {28'd0, bus4.o_led}, {28'd0, e.led4});
    chk("tick", {31'd0, bus8.o_tick}, {31'd0, e.tick});
    chk("tick4", {31'd0, bus4.o_tick}, {31'd0, e.tick});
    chk("run", {31'd0, bus8.o_running}, {31'd0, e.run});
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      cnt = cnt + 32'd1;
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_led8"}, {24'd0, bus8.o_led}, 32'd0);
    chk({tag, "_led4"}, {28'd0, bus4.o_led}, 32'd0);
    chk({tag, "_tick"}, {31'd0, bus8.o_tick}, 32'd0);
    chk({tag, "_run"}, {31'd0, bus8.o_running}, 32'd0);
  endtask

  initial begin
    int guard;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    cnt   = '0;
    en    = 1'b0;
    mode  = 2'd0;
    model_reset();
    #1;
    chk_dark("reset");
    @(negedge clk);
    rst = 1'b0;

    // Chase from enable with a ramping count.
    en   = 1'b1;
    mode = 2'd1;
    cyc();
    cnt = cnt + 32'd1;
    chk("t1_init", {24'd0, bus8.o_led}, 32'h01);
    ramp(75);

    // Ping-pong.
    en = 1'b0;
    ramp(1);
    mode = 2'd2;
    en   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc();
      cnt = cnt + 32'd1;
      chk("pp_onehot", $countones(bus4.o_led), 32'd1);
    end

    // Binary count, then a live switch to blink.
    en = 1'b0;
    ramp(1);
    mode = 2'd3;
    en   = 1'b1;
    ramp(17 * 8 + 4);
    mode = 2'd0;
    ramp(40);

    // Tick bit held high through reset release, then a wrap jump.
    cnt = 32'd4;
    rst = 1'b1;
    #1;
    chk_dark("rst_hold");
    model_reset();
    ramp(2);
    rst = 1'b0;
    ramp(3);
    cnt = 32'hFFFF_FFFF;
    ramp(1);
    cnt = 32'hFFFF_FFFF;
    ramp(1);
    cnt = 32'd0;
    cyc();
    chk("wrap_tick", {31'd0, bus8.o_tick}, 32'd0);
    cyc();
    chk("wrap_tick2", {31'd0, bus8.o_tick}, 32'd0);
    cnt = 32'd1;

    // Mode change between ticks, then disable on an edge.
    en = 1'b0;
    ramp(1);
    mode = 2'd1;
    en   = 1'b1;
    guard = 0;
    ramp(1);
    while (m_led8 != 8'h08 && guard < 100) begin
      ramp(1);
      guard++;
    end
    chk("t5_reach", {24'd0, bus8.o_led}, 32'h08);
    mode = 2'd3;
    ramp(1);
    guard = 0;
    while (cnt[2:0] != 3'd4 && guard < 16) begin
      ramp(1);
      guard++;
    end
    chk("t5_hold", {24'd0, bus8.o_led}, 32'h08);
    ramp(1);
    chk("t5_new", {24'd0, bus8.o_led}, 32'h00);
    ramp(3);
    guard = 0;
    while (cnt[2:0] != 3'd4 && guard < 16) begin
      ramp(1);
      guard++;
    end
    en = 1'b0;
    ramp(1);
    chk("t5_dis_tick", {31'd0, bus8.o_tick}, 32'd1);
    chk("t5_dis_run", {31'd0, bus8.o_running}, 32'd0);
    chk("t5_dis_led", {24'd0, bus8.o_led}, 32'd0);

    // Asynchronous reset mid-cycle while running.
    en   = 1'b1;
    mode = 2'd0;
    ramp(12);
    guard = 0;
    while (!bus8.o_tick && guard < 16) begin
      ramp(1);
      guard++;
    end
    chk("t6_pre_tick", {31'd0, bus8.o_tick}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_dark("t6_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ramp(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
